// File: rtl/piccolo_round_engine.sv
// piccolo_round_engine: iterative Piccolo-80 encryption datapath, one round per clock.
module piccolo_round_engine #(
  parameter int ROUNDS = 25,
  parameter int RKW    = 32 * ROUNDS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [63:0]     pt_i,
  input  logic [63:0]     wk_i,
  input  logic [RKW-1:0]  rk_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [63:0]     ct_o
);
  typedef enum logic {IDLE, RUN} state_e;
  localparam logic [63:0] SBOX = 64'he4b238091a7f6c5d;
  function automatic logic [3:0] sb(input logic [3:0] a);
    return SBOX[{~a, 2'b00} +: 4];
  endfunction
  function automatic logic [3:0] x2(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
  endfunction
  function automatic logic [3:0] x3(input logic [3:0] a);
    return x2(a) ^ a;
  endfunction
  function automatic logic [15:0] f_fn(input logic [15:0] x);
    logic [3:0] s0, s1, s2, s3;
    s0 = sb(x[15:12]);
    s1 = sb(x[11:8]);
    s2 = sb(x[7:4]);
    s3 = sb(x[3:0]);
    return {sb(x2(s0) ^ x3(s1) ^ s2 ^ s3), sb(s0 ^ x2(s1) ^ x3(s2) ^ s3),
            sb(s0 ^ s1 ^ x2(s2) ^ x3(s3)), sb(x3(s0) ^ s1 ^ s2 ^ x2(s3))};
  endfunction
  function automatic logic [63:0] rp(input logic [63:0] x);
    return {x[47:40], x[7:0], x[31:24], x[55:48], x[15:8], x[39:32], x[63:56], x[23:16]};
  endfunction
  state_e      state_q;
  logic [4:0]  ctr_q;
  logic [63:0] x_q, x_d, ct_q;
  logic        busy_q, done_q;
  logic [31:0] rk_arr [32];
  logic [31:0] rk_j;
  genvar g;
  for (g = 0; g < 32; g++) begin : g_rk
    if (g < ROUNDS) begin : g_use
      assign rk_arr[g] = rk_i[RKW-1-32*g -: 32];
    end else begin : g_pad
      assign rk_arr[g] = '0;
    end
  end
  assign rk_j = rk_arr[ctr_q];
  always_comb begin
    x_d = x_q;
    x_d[47:32] = x_q[47:32] ^ f_fn(x_q[63:48]) ^ rk_j[31:16];
    x_d[15:0]  = x_q[15:0]  ^ f_fn(x_q[31:16]) ^ rk_j[15:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      x_q     <= '0;
      ct_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start_i) begin
          x_q     <= {pt_i[63:48] ^ wk_i[15:0], pt_i[47:32], pt_i[31:16] ^ wk_i[31:16], pt_i[15:0]};
          ctr_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= RUN;
        end
      end else if (ctr_q == 5'(ROUNDS - 1)) begin
        // final round skips RP and applies output whitening
        ct_q    <= {x_d[63:48] ^ wk_i[47:32], x_d[47:32], x_d[31:16] ^ wk_i[63:48], x_d[15:0]};
        done_q  <= 1'b1;
        busy_q  <= 1'b0;
        state_q <= IDLE;
      end else begin
        x_q   <= rp(x_d);
        ctr_q <= ctr_q + 5'd1;
      end
    end
  end
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign ct_o   = ct_q;
endmodule
